vector_result_serializer: RTL
=============================

Name: vector_result_serializer

Overview:
- Receiving end of the registered vector-adder interface.
- Captures a full parallel sum vector on the adder's one-cycle outReady pulse, which is wired to this block's inReady input.
- Streams the captured elements one per cycle to a downstream consumer (matrix row writer / memory port) under a valid/accept handshake.
- A one-deep shadow buffer absorbs a second vector while the first is still draining.

Parameters:
- IN_WIDTH, 16, operand width of the upstream adder; each sum element is IN_WIDTH+1 bits signed.
- VEC_LEN, 12, number of elements per vector (≥1).
- IDX_WIDTH, 4, width of outIndex; must satisfy 2^IDX_WIDTH ≥ VEC_LEN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global clock-enable; low freezes all state.
- inReady  input  1  one-cycle pulse: inVec holds a valid sum vector.
- inVec  input  VEC_LEN*(IN_WIDTH+1)  packed sum vector; element i occupies bits [(i+1)*(IN_WIDTH+1)-1 : i*(IN_WIDTH+1)].
- outAccept  input  1  downstream ready to take the current element.
- outValid  output  1  outData/outIndex/outLast are valid.
- outData  output  IN_WIDTH+1  current element, signed.
- outIndex  output  IDX_WIDTH  index of the current element.
- outLast  output  1  current element is index VEC_LEN-1.
- busy  output  1  active buffer holds a vector.
- canAccept  output  1  shadow buffer empty; a new vector will not be dropped.
- overflow  output  1  sticky: a vector was dropped.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered except canAccept, which is decoded from the shadowFull register.
- Reset values: outValid=0, outData=0, outIndex=0, outLast=0, busy=0, overflow=0, shadowFull=0 (so canAccept=1), state=IDLE.
- Enable low: no capture, no index advance, outputs hold; inReady pulses are ignored and overflow is not set. Reset overrides enable.
- Transfer: a transfer occurs on a cycle where enable && outValid && outAccept.
- State IDLE (busy=0, outValid=0):
  - On enable && inReady: load the active buffer from inVec.
  - Next cycle: STREAM with outIndex=0, outData=element 0, outValid=1. Latency is inReady at cycle t → first element valid at t+1.
- State STREAM (busy=1, outValid=1):
  - On a transfer that is not the last element: outIndex+1 and outData=next element.
  - Without a transfer: outData, outIndex and outLast hold stable.
- Last-element transfer (outIndex = VEC_LEN-1):
  - If shadowFull: active ← shadow, shadowFull ← 0, outIndex ← 0; stay in STREAM.
  - Else if inReady the same cycle: active ← inVec, outIndex ← 0; stay in STREAM.
  - Else: go to IDLE; outValid ← 0.
  - Back-to-back vectors therefore stream with no bubble.
- inReady while STREAM (and not consumed by the last-transfer rule above):
  - If shadowFull=0: shadow ← inVec, shadowFull ← 1.
  - Else: drop the vector and set overflow ← 1. Overflow clears only on reset.
- Simultaneous events:
  - Last transfer + shadowFull + inReady: shadow moves to active and the incoming vector is written to shadow (shadowFull stays 1). No drop.
  - Non-last transfer + inReady with shadowFull=1: the incoming vector is dropped.
- outLast = (outIndex == VEC_LEN-1) && outValid. When VEC_LEN=1, every element is last.
- Reset mid-stream: all buffered data is discarded and outputs return to reset values the next cycle.
- Arithmetic: none by default. Elements pass bit-exact at IN_WIDTH+1 bits.

Optional Feature:
- Macro: VEC_SERIALIZER_SATURATE_EN.
- Defined: before registering into outData, each element is clamped to the signed IN_WIDTH range [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1] and sign-extended back to IN_WIDTH+1 bits. Clamping adds no latency.
- Undefined: elements pass through unmodified.

Test Plan:
1. Reset; single vector with element k = 100*k-600 (k=0..11), outAccept=1, inReady at cycle 10 → outValid high cycles 11–22, outIndex 0..11, outData -600..500, outLast only at cycle 22, busy low at cycle 23.
2. Backpressure: outAccept=0 for 3 cycles while outIndex=5 → outData stays -100, index 5 held; resumes at 6 with no element skipped or duplicated.
3. Back-to-back: second inReady on the cycle element 11 transfers → next cycle outIndex=0 with the new vector's element 0; 24 consecutive valid cycles, shadowFull never set.
4. Overflow: three inReady pulses on consecutive cycles with outAccept=0 → active=V1, shadow=V2, canAccept=0, overflow=1 (V3 dropped); then outAccept=1 drains exactly 24 elements matching V1 then V2.
5. Enable low for 4 cycles mid-stream (outIndex=7), with an inReady pulse inside that window → outputs frozen, pulse ignored, overflow stays 0; streaming resumes at index 7.
6. With VEC_SERIALIZER_SATURATE_EN defined: elements 32768 and -32769 → outData 32767 and -32768. Without the macro → 32768 and -32769 unchanged.

Source files
------------

// File: rtl/vector_result_serializer.sv
// Receives a parallel sum vector from the registered vector adder and streams it one element per cycle.
// Optional build macro VEC_SERIALIZER_SATURATE_EN clamps each element to the signed IN_WIDTH range.
module vector_result_serializer #(
    parameter int IN_WIDTH  = 16,
    parameter int VEC_LEN   = 12,
    parameter int IDX_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              inReady,
    input  logic [VEC_LEN*(IN_WIDTH+1)-1:0]   inVec,
    input  logic                              outAccept,
    output logic                              outValid,
    output logic [IN_WIDTH:0]                 outData,
    output logic [IDX_WIDTH-1:0]              outIndex,
    output logic                              outLast,
    output logic                              busy,
    output logic                              canAccept,
    output logic                              overflow
);
    localparam int EW = IN_WIDTH + 1;
    localparam int VW = VEC_LEN * EW;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VEC_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
    localparam logic                 SINGLE   = (VEC_LEN == 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_reg;
    logic [VW-1:0]          active_reg;
    logic [VW-1:0]          shadow_reg;
    logic                   shadow_full_reg;
    logic [IDX_WIDTH-1:0]   idx_reg;
    logic [EW-1:0]          data_reg;
    logic                   valid_reg;
    logic                   last_reg;
    logic                   busy_reg;
    logic                   overflow_reg;

    logic [EW-1:0]          active_elem [VEC_LEN];
    logic [IDX_WIDTH-1:0]   idx_next;
    logic [EW-1:0]          elem_next;

    generate
        for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_unpack
            assign active_elem[gi] = active_reg[gi*EW +: EW];
        end
    endgenerate

    // Only read when the current element is not the last, so idx_next stays in range.
    assign idx_next  = idx_reg + IDX_ONE;
    assign elem_next = active_elem[idx_next];

`ifdef VEC_SERIALIZER_SATURATE_EN
    // A sum exceeds the IN_WIDTH range exactly when its top two bits disagree.
    function automatic logic [EW-1:0] shape(input logic [EW-1:0] e);
        if (e[EW-1] != e[EW-2])
            return e[EW-1] ? {2'b11, {(IN_WIDTH-1){1'b0}}} : {2'b00, {(IN_WIDTH-1){1'b1}}};
        return e;
    endfunction
`else
    function automatic logic [EW-1:0] shape(input logic [EW-1:0] e);
        return e;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            active_reg      <= '0;
            shadow_reg      <= '0;
            shadow_full_reg <= 1'b0;
            idx_reg         <= '0;
            data_reg        <= '0;
            valid_reg       <= 1'b0;
            last_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (inReady) begin
                        active_reg <= inVec;
                        data_reg   <= shape(inVec[EW-1:0]);
                        idx_reg    <= '0;
                        last_reg   <= SINGLE;
                        valid_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        state_reg  <= STREAM;
                    end
                end
                STREAM: begin
                    if (outAccept && idx_reg == LAST_IDX) begin
                        // Vector finished: chain the next one with no bubble if one is available.
                        if (shadow_full_reg) begin
                            active_reg <= shadow_reg;
                            data_reg   <= shape(shadow_reg[EW-1:0]);
                            idx_reg    <= '0;
                            last_reg   <= SINGLE;
                            if (inReady)
                                shadow_reg <= inVec;
                            else
                                shadow_full_reg <= 1'b0;
                        end else if (inReady) begin
                            active_reg <= inVec;
                            data_reg   <= shape(inVec[EW-1:0]);
                            idx_reg    <= '0;
                            last_reg   <= SINGLE;
                        end else begin
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            last_reg  <= 1'b0;
                            idx_reg   <= '0;
                            data_reg  <= '0;
                        end
                    end else begin
                        if (outAccept) begin
                            idx_reg  <= idx_next;
                            data_reg <= shape(elem_next);
                            last_reg <= (idx_next == LAST_IDX);
                        end
                        if (inReady) begin
                            if (!shadow_full_reg) begin
                                shadow_reg      <= inVec;
                                shadow_full_reg <= 1'b1;
                            end else begin
                                overflow_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign outValid  = valid_reg;
    assign outData   = data_reg;
    assign outIndex  = idx_reg;
    assign outLast   = last_reg;
    assign busy      = busy_reg;
    assign overflow  = overflow_reg;
    assign canAccept = ~shadow_full_reg;

endmodule
